awgn_frame_ctrl: RTL and testbench
==================================

AWGN_FRAME_CTRL -- requirements
Module: awgn_frame_ctrl

Interface
REQ-001 Parameter: FRAME_W, 20, width of the frame length and sample counters (supports 320000 samples).
REQ-002 Parameter: DRAIN_TMO, 64, maximum idle cycles in DRAIN before timeout.
REQ-003 Port: clk  in  1  single clock, rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-low reset.
REQ-005 Port: start  in  1  one-cycle pulse that begins a frame; accepted in IDLE or DONE only.
REQ-006 Port: frame_len  in  FRAME_W  samples per frame; latched on accepted start.
REQ-007 Port: src_valid / src_ready  in / out  1  upstream handshake; a transfer occurs when both are high.
REQ-008 Port: src_real, src_imag  in  16  signed upstream sample.
REQ-009 Port: awgn_read  out  1  drives the channel read input.
REQ-010 Port: awgn_x_real, awgn_x_imag  out  16  samples to the channel.
REQ-011 Port: awgn_busy  in  1  channel output-valid flag.
REQ-012 Port: awgn_y_real, awgn_y_imag  in  16  channel output; awgn_noise  in  12  truncated real noise.
REQ-013 Port: dst_valid, dst_last  out  1  output-valid flag and last-sample flag; there is no downstream backpressure.
REQ-014 Port: dst_real, dst_imag  out  16  registered channel output.
REQ-015 Port: in_cnt, out_cnt  out  FRAME_W  samples issued and samples collected in the current frame.
REQ-016 Port: busy, done, err  out  1  frame in progress, frame complete (level), drain timeout.

Function
REQ-017 FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE->RUN on start with frame_len!=0.
- RUN->DRAIN when in_cnt reaches frame_len.
- DRAIN->DONE when out_cnt reaches frame_len or on timeout.
REQ-018 start with frame_len==0 leaves the state unchanged and pulses err for 1 cycle; start in RUN or DRAIN is ignored.
REQ-019 Entry to RUN clears in_cnt, out_cnt, err and done in the same edge.
REQ-020 src_ready = (state==RUN) and (in_cnt<frame_len), combinational.
REQ-021 On each src transfer, awgn_x_* is registered from src_* and awgn_read is high the next cycle; otherwise awgn_read is low and awgn_x_* hold their value.
REQ-022 in_cnt increments on each src transfer.
REQ-023 In RUN or DRAIN, when awgn_busy=1 and out_cnt<frame_len:
- dst_* register awgn_y_*, dst_valid=1 the next cycle, out_cnt increments.
- dst_last=1 with the sample that makes out_cnt==frame_len.
REQ-024 awgn_busy while in IDLE/DONE, or after out_cnt==frame_len, is discarded.
REQ-025 DRAIN timer: resets on each collected sample; when it reaches DRAIN_TMO, set err=1 (sticky until next accepted start) and go to DONE.
REQ-026 A transfer and a collection in the same cycle both count; simultaneous last-input and first-output is legal.
REQ-027 busy=1 in RUN and DRAIN; done=1 in DONE.
REQ-028 Counters do not wrap; they saturate at frame_len.

Reset
REQ-029 reset low asynchronously forces IDLE, and forces every output, counter and timer to 0; this includes src_ready, awgn_read, dst_valid and err.
REQ-030 Reset asserted mid-frame abandons the frame; after release the block is in IDLE and waits for start.

Configuration
REQ-031 Macro AWGN_CTRL_NOISE_STATS_EN, when defined, adds port noise_sum (out, 32, signed).
- noise_sum accumulates sign-extended awgn_noise on every collected sample.
- It clears on accepted start and on reset.
REQ-032 Without AWGN_CTRL_NOISE_STATS_EN, there is no noise_sum port, no accumulator logic, and awgn_noise is unused.

Structure
REQ-033 A shared package awgn_pkg holds:
- the FSM state enum;
- sample width 16 and noise width 12;
- the default FRAME_W.
REQ-034 Sub-module awgn_sample_counter (saturating FRAME_W-bit counter with clear, inc and limit) is instantiated twice, for in_cnt and out_cnt.

Verification
REQ-035 frame_len=4, src_valid always 1, channel latency 3:
- awgn_read high for 4 cycles;
- 4 dst_valid pulses, dst_last on the 4th;
- done=1, err=0, in_cnt=out_cnt=4.
REQ-036 frame_len=8, src_valid toggling 1/0: awgn_read mirrors the transfers, and in_cnt reaches 8 after 15 cycles.
REQ-037 frame_len=3, channel never asserts busy: DRAIN lasts 64 cycles, then DONE with err=1 and out_cnt=0.
REQ-038 Reset low during RUN at in_cnt=2: all outputs are 0 within the same cycle, state is IDLE, and a new start runs normally.
REQ-039 start with frame_len=0: 1-cycle err pulse, and the block stays IDLE; start during RUN: no effect on the counters.
REQ-040 With AWGN_CTRL_NOISE_STATS_EN and noise samples 5, -3, 2047, -2048: noise_sum=1.

Source files
------------

// File: rtl/awgn_pkg.sv
// Shared types and widths for the AWGN channel frame controller.
package awgn_pkg;

  localparam int SAMPLE_W      = 16;
  localparam int NOISE_W       = 12;
  localparam int FRAME_W_DEF   = 20;
  localparam int DRAIN_TMO_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/awgn_sample_counter.sv
// Saturating sample counter: clear wins over increment, and the count
// never moves past the limit.
module awgn_sample_counter
  import awgn_pkg::*;
#(
  parameter int W = FRAME_W_DEF
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q < limit_i)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/awgn_frame_ctrl.sv
// Frame controller feeding samples into an AWGN channel and collecting its output.
// Optional noise accumulator port noise_sum_o is enabled by AWGN_CTRL_NOISE_STATS_EN.
module awgn_frame_ctrl
  import awgn_pkg::*;
#(
  parameter int FRAME_W   = FRAME_W_DEF,
  parameter int DRAIN_TMO = DRAIN_TMO_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic [FRAME_W-1:0]         frame_len_i,
  input  logic                       src_valid_i,
  output logic                       src_ready_o,
  input  logic signed [SAMPLE_W-1:0] src_real_i,
  input  logic signed [SAMPLE_W-1:0] src_imag_i,
  output logic                       awgn_read_o,
  output logic signed [SAMPLE_W-1:0] awgn_x_real_o,
  output logic signed [SAMPLE_W-1:0] awgn_x_imag_o,
  input  logic                       awgn_busy_i,
  input  logic signed [SAMPLE_W-1:0] awgn_y_real_i,
  input  logic signed [SAMPLE_W-1:0] awgn_y_imag_i,
  input  logic signed [NOISE_W-1:0]  awgn_noise_i,
  output logic                       dst_valid_o,
  output logic                       dst_last_o,
  output logic signed [SAMPLE_W-1:0] dst_real_o,
  output logic signed [SAMPLE_W-1:0] dst_imag_o,
  output logic [FRAME_W-1:0]         in_cnt_o,
  output logic [FRAME_W-1:0]         out_cnt_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o
`ifdef AWGN_CTRL_NOISE_STATS_EN
  ,
  output logic signed [31:0]         noise_sum_o
`endif
);

  localparam int TMO_W = $clog2(DRAIN_TMO + 1);

  state_e                state_q, state_d;
  logic [FRAME_W-1:0]    frameLen_q, frameLen_d;
  logic [TMO_W-1:0]      drainTmr_q, drainTmr_d;
  logic                  errSticky_q, errSticky_d;
  logic                  errPulse_q, errPulse_d;
  logic                  awgnRead_q, awgnRead_d;
  logic [SAMPLE_W-1:0]   xReal_q, xReal_d, xImag_q, xImag_d;
  logic                  dstValid_q, dstValid_d;
  logic                  dstLast_q, dstLast_d;
  logic [SAMPLE_W-1:0]   dstReal_q, dstReal_d, dstImag_q, dstImag_d;

  logic                  startWindow, startAccept, startReject;
  logic                  xfer, collect, lastIn, lastOut, tmoHit;
  logic [FRAME_W-1:0]    inCnt, outCnt;

  always_comb begin
    startWindow = (state_q == ST_IDLE) || (state_q == ST_DONE);
    startAccept = start_i && startWindow && (frame_len_i != '0);
    startReject = start_i && startWindow && (frame_len_i == '0);
    src_ready_o = (state_q == ST_RUN) && (inCnt < frameLen_q);
    xfer        = src_valid_i && src_ready_o;
    collect     = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) &&
                  awgn_busy_i && (outCnt < frameLen_q);
    lastIn      = xfer && (inCnt == frameLen_q - 1'b1);
    lastOut     = collect && (outCnt == frameLen_q - 1'b1);
    tmoHit      = (state_q == ST_DRAIN) && !collect &&
                  (drainTmr_q == TMO_W'(DRAIN_TMO - 1));
  end

  // Transitions fire on the edge that completes the count, so DRAIN
  // is entered with in_cnt already equal to the frame length.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (startAccept) state_d = ST_RUN;
      ST_RUN:           if (lastIn) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (lastOut || (outCnt == frameLen_q) || tmoHit) state_d = ST_DONE;
      end
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    frameLen_d  = startAccept ? frame_len_i : frameLen_q;
    drainTmr_d  = '0;
    if (state_q == ST_DRAIN && !collect) drainTmr_d = drainTmr_q + 1'b1;
    errSticky_d = errSticky_q;
    if (startAccept)  errSticky_d = 1'b0;
    else if (tmoHit)  errSticky_d = 1'b1;
    errPulse_d  = startReject;
    awgnRead_d  = xfer;
    xReal_d     = xfer ? src_real_i : xReal_q;
    xImag_d     = xfer ? src_imag_i : xImag_q;
    dstValid_d  = collect;
    dstLast_d   = lastOut;
    dstReal_d   = collect ? awgn_y_real_i : dstReal_q;
    dstImag_d   = collect ? awgn_y_imag_i : dstImag_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      frameLen_q  <= '0;
      drainTmr_q  <= '0;
      errSticky_q <= 1'b0;
      errPulse_q  <= 1'b0;
      awgnRead_q  <= 1'b0;
      xReal_q     <= '0;
      xImag_q     <= '0;
      dstValid_q  <= 1'b0;
      dstLast_q   <= 1'b0;
      dstReal_q   <= '0;
      dstImag_q   <= '0;
    end else begin
      state_q     <= state_d;
      frameLen_q  <= frameLen_d;
      drainTmr_q  <= drainTmr_d;
      errSticky_q <= errSticky_d;
      errPulse_q  <= errPulse_d;
      awgnRead_q  <= awgnRead_d;
      xReal_q     <= xReal_d;
      xImag_q     <= xImag_d;
      dstValid_q  <= dstValid_d;
      dstLast_q   <= dstLast_d;
      dstReal_q   <= dstReal_d;
      dstImag_q   <= dstImag_d;
    end
  end

  awgn_sample_counter #(.W(FRAME_W)) u_in_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (startAccept),
    .inc_i   (xfer),
    .limit_i (frameLen_q),
    .cnt_o   (inCnt)
  );

  awgn_sample_counter #(.W(FRAME_W)) u_out_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (startAccept),
    .inc_i   (collect),
    .limit_i (frameLen_q),
    .cnt_o   (outCnt)
  );

`ifdef AWGN_CTRL_NOISE_STATS_EN
  logic signed [31:0] noiseSum_q, noiseSum_d;

  always_comb begin
    noiseSum_d = noiseSum_q;
    if (startAccept) begin
      noiseSum_d = '0;
    end else if (collect) begin
      noiseSum_d = noiseSum_q +
                   {{(32 - NOISE_W){awgn_noise_i[NOISE_W-1]}}, awgn_noise_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      noiseSum_q <= '0;
    end else begin
      noiseSum_q <= noiseSum_d;
    end
  end

  assign noise_sum_o = noiseSum_q;
`else
  logic unused_noise;
  assign unused_noise = ^awgn_noise_i;
`endif

  assign awgn_read_o   = awgnRead_q;
  assign awgn_x_real_o = xReal_q;
  assign awgn_x_imag_o = xImag_q;
  assign dst_valid_o   = dstValid_q;
  assign dst_last_o    = dstLast_q;
  assign dst_real_o    = dstReal_q;
  assign dst_imag_o    = dstImag_q;
  assign in_cnt_o      = inCnt;
  assign out_cnt_o     = outCnt;
  assign busy_o        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done_o        = (state_q == ST_DONE);
  assign err_o         = errSticky_q | errPulse_q;

endmodule

// File: tb/tb_awgn_frame_ctrl.sv
// Self-checking bench for awgn_frame_ctrl with a behavioural 3-cycle channel model.
// Noise statistics are checked when AWGN_CTRL_NOISE_STATS_EN is defined.
module tb_awgn_frame_ctrl;

  localparam int FW  = 20;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [FW-1:0] frameLen = '0;
  logic          srcValid = 1'b0;
  logic          srcReady;
  logic [15:0]   srcReal = '0, srcImag = '0;
  logic          awgnRead;
  logic [15:0]   awgnXReal, awgnXImag;
  logic          awgnBusy;
  logic [15:0]   awgnYReal, awgnYImag;
  logic [11:0]   awgnNoise;
  logic          dstValid, dstLast;
  logic [15:0]   dstReal, dstImag;
  logic [FW-1:0] inCnt, outCnt;
  logic          busy, done, err;
`ifdef AWGN_CTRL_NOISE_STATS_EN
  logic [31:0]   noiseSum;
`endif

  int checks = 0;
  int errors = 0;
  int curLen = 0;
  int drainTotal = 0;
  bit chanEn = 1'b1;
  bit noiseTable = 1'b0;

  logic [31:0] sentQ[$];
  logic [31:0] xQ[$];
  logic [31:0] dstQ[$];
  logic        lastQ[$];
  logic [11:0] noiseOutQ[$];

  always #5 clk = ~clk;

  awgn_frame_ctrl #(.FRAME_W(FW), .DRAIN_TMO(64)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_i       (start),
    .frame_len_i   (frameLen),
    .src_valid_i   (srcValid),
    .src_ready_o   (srcReady),
    .src_real_i    (srcReal),
    .src_imag_i    (srcImag),
    .awgn_read_o   (awgnRead),
    .awgn_x_real_o (awgnXReal),
    .awgn_x_imag_o (awgnXImag),
    .awgn_busy_i   (awgnBusy),
    .awgn_y_real_i (awgnYReal),
    .awgn_y_imag_i (awgnYImag),
    .awgn_noise_i  (awgnNoise),
    .dst_valid_o   (dstValid),
    .dst_last_o    (dstLast),
    .dst_real_o    (dstReal),
    .dst_imag_o    (dstImag),
    .in_cnt_o      (inCnt),
    .out_cnt_o     (outCnt),
    .busy_o        (busy),
    .done_o        (done),
    .err_o         (err)
`ifdef AWGN_CTRL_NOISE_STATS_EN
    ,
    .noise_sum_o   (noiseSum)
`endif
  );

  // Channel model: fixed latency, deterministic transform, per-sample noise.
  logic [LAT-1:0] vPipe = '0;
  logic [15:0]    rPipe [LAT];
  logic [15:0]    iPipe [LAT];
  logic [11:0]    nPipe [LAT];
  logic [11:0]    noiseTbl [4] = '{12'd5, 12'hFFD, 12'h7FF, 12'h800};
  int             noiseIdx = 0;

  always @(posedge clk) begin
    vPipe    <= {vPipe[LAT-2:0], awgnRead};
    rPipe[0] <= awgnXReal;
    iPipe[0] <= awgnXImag;
    if (awgnRead) nPipe[0] <= noiseTable ? noiseTbl[noiseIdx % 4] : 12'($urandom);
    else          nPipe[0] <= '0;
    if (!noiseTable)   noiseIdx <= 0;
    else if (awgnRead) noiseIdx <= noiseIdx + 1;
    for (int k = 1; k < LAT; k++) begin
      rPipe[k] <= rPipe[k-1];
      iPipe[k] <= iPipe[k-1];
      nPipe[k] <= nPipe[k-1];
    end
    if (awgnBusy) noiseOutQ.push_back(awgnNoise);
  end

  assign awgnBusy  = chanEn && vPipe[LAT-1];
  assign awgnYReal = rPipe[LAT-1] ^ 16'hA5A5;
  assign awgnYImag = iPipe[LAT-1] + 16'd7;
  assign awgnNoise = nPipe[LAT-1];

  function automatic logic [31:0] chanModel(input logic [31:0] s);
    return {s[31:16] ^ 16'hA5A5, s[15:0] + 16'd7};
  endfunction

  always @(posedge clk) begin
    if (rst_n && srcValid && srcReady) sentQ.push_back({srcReal, srcImag});
  end

  always @(negedge clk) begin
    if (awgnRead) xQ.push_back({awgnXReal, awgnXImag});
    if (dstValid) begin
      dstQ.push_back({dstReal, dstImag});
      lastQ.push_back(dstLast);
    end
    if (busy && (inCnt == FW'(curLen))) drainTotal++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a drive point (just after a rising edge); returns at the next one.
  task automatic pulseStart(input int len);
    start    = 1'b1;
    frameLen = FW'(len);
    @(posedge clk); #2;
    start    = 1'b0;
    frameLen = FW'($urandom);
  endtask

  // mode: 0 = valid always high, 1 = valid toggling 1/0, 2 = random valid
  task automatic applyStimulus(input int len, input int mode, input bit chan, input bit midStart);
    int  sBase, xBase, dBase, nBase, drBase, lastCount;
    bit  seen;
    longint expSum;
    chanEn = chan;
    curLen = len;
    sBase  = sentQ.size();
    xBase  = xQ.size();
    dBase  = dstQ.size();
    nBase  = noiseOutQ.size();
    drBase = drainTotal;
    pulseStart(len);
    seen = 1'b0;
    for (int cyc = 1; cyc <= 400 && !seen; cyc++) begin
      srcValid = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : ($urandom_range(0, 2) != 0);
      srcReal  = 16'($urandom);
      srcImag  = 16'($urandom);
      if (midStart && cyc == 3) begin
        start    = 1'b1;
        frameLen = FW'(2);
      end else begin
        start    = 1'b0;
      end
      @(negedge clk);
      if (mode == 1 && cyc == 15) checkOutput("toggle_in_cnt_c15", 32'(inCnt), 32'd7);
      if (mode == 1 && cyc == 16) checkOutput("toggle_in_cnt_c16", 32'(inCnt), 32'd8);
      seen = done;
      @(posedge clk); #2;
    end
    start    = 1'b0;
    srcValid = 1'b0;
    checkOutput($sformatf("len%0d_done_reached", len), 32'(seen), 32'd1);
    checkOutput($sformatf("len%0d_busy", len), 32'(busy), 32'd0);
    checkOutput($sformatf("len%0d_in_cnt", len), 32'(inCnt), 32'(len));
    checkOutput($sformatf("len%0d_transfers", len), 32'(sentQ.size() - sBase), 32'(len));
    checkOutput($sformatf("len%0d_read_cycles", len), 32'(xQ.size() - xBase), 32'(len));
    for (int i = 0; i < len && (sBase + i) < sentQ.size() && (xBase + i) < xQ.size(); i++)
      checkOutput($sformatf("len%0d_x%0d", len, i), xQ[xBase + i], sentQ[sBase + i]);
    if (chan) begin
      checkOutput($sformatf("len%0d_err", len), 32'(err), 32'd0);
      checkOutput($sformatf("len%0d_out_cnt", len), 32'(outCnt), 32'(len));
      checkOutput($sformatf("len%0d_dst_count", len), 32'(dstQ.size() - dBase), 32'(len));
      lastCount = 0;
      for (int i = 0; (dBase + i) < dstQ.size(); i++) begin
        if (lastQ[dBase + i]) lastCount++;
        if (i < len && (sBase + i) < sentQ.size())
          checkOutput($sformatf("len%0d_dst%0d", len, i), dstQ[dBase + i], chanModel(sentQ[sBase + i]));
      end
      checkOutput($sformatf("len%0d_last_count", len), 32'(lastCount), 32'd1);
      if ((dBase + len - 1) < lastQ.size())
        checkOutput($sformatf("len%0d_last_pos", len), 32'(lastQ[dBase + len - 1]), 32'd1);
      expSum = 0;
      for (int i = 0; i < len && (nBase + i) < noiseOutQ.size(); i++)
        expSum += longint'($signed(noiseOutQ[nBase + i]));
`ifdef AWGN_CTRL_NOISE_STATS_EN
      checkOutput($sformatf("len%0d_noise_sum", len), noiseSum, 32'(expSum));
`endif
    end else begin
      checkOutput($sformatf("len%0d_err_tmo", len), 32'(err), 32'd1);
      checkOutput($sformatf("len%0d_out_cnt_tmo", len), 32'(outCnt), 32'd0);
      checkOutput($sformatf("len%0d_dst_count_tmo", len), 32'(dstQ.size() - dBase), 32'd0);
      checkOutput($sformatf("len%0d_drain_cycles", len), 32'(drainTotal - drBase), 32'd64);
    end
  endtask

  initial begin
    bit seen;
    // Reset state
    repeat (2) @(posedge clk);
    #2;
    checkOutput("rst_src_ready", 32'(srcReady), 32'd0);
    checkOutput("rst_awgn_read", 32'(awgnRead), 32'd0);
    checkOutput("rst_dst_valid", 32'(dstValid), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_busy_done", 32'({busy, done}), 32'd0);
    checkOutput("rst_counts", 32'({inCnt, outCnt}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #2;

    // Zero-length start from IDLE: one-cycle err pulse, no state change
    pulseStart(0);
    @(negedge clk);
    checkOutput("zero_len_err_pulse", 32'(err), 32'd1);
    checkOutput("zero_len_idle", 32'({busy, done}), 32'd0);
    @(posedge clk); #2;
    @(negedge clk);
    checkOutput("zero_len_err_clear", 32'(err), 32'd0);
    @(posedge clk); #2;

    $display("[TB] basic frame, len 4");
    applyStimulus(4, 0, 1'b1, 1'b0);
    $display("[TB] toggling valid, len 8");
    applyStimulus(8, 1, 1'b1, 1'b0);
    $display("[TB] random frames");
    for (int r = 0; r < 4; r++) applyStimulus($urandom_range(3, 12), 2, 1'b1, 1'b0);
    $display("[TB] start during RUN is ignored");
    applyStimulus(6, 0, 1'b1, 1'b1);
    $display("[TB] drain timeout, len 3");
    applyStimulus(3, 0, 1'b0, 1'b0);

    // Zero-length start in DONE keeps done and the sticky timeout error
    pulseStart(0);
    @(negedge clk);
    checkOutput("done_zero_len_err", 32'(err), 32'd1);
    checkOutput("done_zero_len_done", 32'(done), 32'd1);
    @(posedge clk); #2;
    @(negedge clk);
    checkOutput("done_err_sticky", 32'(err), 32'd1);
    @(posedge clk); #2;

    $display("[TB] reset in the middle of a frame");
    chanEn = 1'b1;
    curLen = 6;
    pulseStart(6);
    srcValid = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      seen = (inCnt == FW'(2));
      if (!seen) begin
        @(posedge clk); #2;
      end
    end
    checkOutput("mid_reached_in2", 32'(seen), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_src_ready", 32'(srcReady), 32'd0);
    checkOutput("mid_rst_awgn_read", 32'(awgnRead), 32'd0);
    checkOutput("mid_rst_dst", 32'({dstValid, dstLast}), 32'd0);
    checkOutput("mid_rst_err_busy_done", 32'({err, busy, done}), 32'd0);
    checkOutput("mid_rst_counts", 32'({inCnt, outCnt}), 32'd0);
    checkOutput("mid_rst_x", 32'({awgnXReal, awgnXImag}), 32'd0);
    srcValid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #2;
    @(negedge clk);
    checkOutput("post_rst_idle", 32'({busy, done, err}), 32'd0);
    @(posedge clk); #2;
    applyStimulus(4, 0, 1'b1, 1'b0);

`ifdef AWGN_CTRL_NOISE_STATS_EN
    $display("[TB] noise table 5, -3, 2047, -2048");
    noiseTable = 1'b1;
    @(posedge clk); #2;
    applyStimulus(4, 0, 1'b1, 1'b0);
    checkOutput("noise_table_sum", noiseSum, 32'd1);
    noiseTable = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
